// File: rtl/tdc_reader_pkg.sv
// Shared types and constants for the TDC frame reader: FSM state encoding,
// frame header byte and the sum byte-count helper.
package tdc_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_SEND
  } state_e;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Number of bytes needed to carry a sum of the given bit width.
  function automatic int sum_bytes(input int sum_w);
    return (sum_w + 7) / 8;
  endfunction

endpackage

// File: rtl/tdc_frame_reader_if.sv
// Byte-wide valid/ready link from the frame reader toward the output pins.
interface tdc_frame_reader_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/tdc_win_stats.sv
// Windowed min/max/sum accumulator over Hamming-weight samples.
// clr_i restarts the window; last_o flags the accept that completes it.
module tdc_win_stats #(
  parameter int HW_W     = 7,
  parameter int LOG2_WIN = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     acc_i,
  input  logic [HW_W-1:0]          hw_i,
  output logic [HW_W-1:0]          min_o,
  output logic [HW_W-1:0]          max_o,
  output logic [HW_W+LOG2_WIN-1:0] sum_o,
  output logic                     last_o
);

  localparam int SUM_W = HW_W + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_WIN) - 1);

  logic [HW_W-1:0]  min_q, max_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;

  // Clear to neutral values on reset/clear, otherwise fold in each accepted sample.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else if (acc_i) begin
      if (hw_i < min_q) min_q <= hw_i;
      if (hw_i > max_q) max_q <= hw_i;
      sum_q <= sum_q + SUM_W'(hw_i);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign min_o  = min_q;
  assign max_o  = max_q;
  assign sum_o  = sum_q;
  assign last_o = acc_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/tdc_frame_reader.sv
// TDC frame reader: on start, skips SETTLE accepted samples, accumulates
// min/max/sum over 2^LOG2_WIN samples, then sends the result as a byte frame.
// Optional build macro TDC_READER_CHKSUM_EN appends an XOR checksum byte.
module tdc_frame_reader
  import tdc_reader_pkg::*;
#(
  parameter int N        = 64,
  parameter int LOG2_WIN = 8,
  parameter int SETTLE   = 4
) (
  input  logic                  clk_capture,
  input  logic                  rst,
  input  logic                  en,
  input  logic [$clog2(N):0]    hw,
  input  logic                  start,
  tdc_frame_reader_if.master    out_if,
  output logic                  busy
);

  localparam int HW_W      = $clog2(N) + 1;
  localparam int SUM_W     = HW_W + LOG2_WIN;
  localparam int SUM_BYTES = sum_bytes(SUM_W);
  localparam int SUM_PAD_W = 8 * SUM_BYTES;
`ifdef TDC_READER_CHKSUM_EN
  localparam int FRAME_LEN = 5 + SUM_BYTES;
`else
  localparam int FRAME_LEN = 4 + SUM_BYTES;
`endif
  localparam logic [3:0] LAST_IDX    = 4'(FRAME_LEN - 1);
  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e           state_q;
  logic [3:0]       idx_q;
  logic [7:0]       seq_q;
  logic [7:0]       settle_cnt_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [HW_W-1:0]  stat_min, stat_max;
  logic [SUM_W-1:0] stat_sum;
  logic             win_last;
  logic             stat_clr, stat_acc;

  logic [3:0]           nxt_idx;
  logic [SUM_PAD_W-1:0] sum_pad;
  logic [7:0]           min8, max8;
  logic [7:0]           nxt_byte_d;

  assign stat_clr = (state_q == ST_IDLE) && start;
  assign stat_acc = (state_q == ST_ACCUM) && en;

  tdc_win_stats #(
    .HW_W     (HW_W),
    .LOG2_WIN (LOG2_WIN)
  ) u_stats (
    .clk_i  (clk_capture),
    .rst_i  (rst),
    .clr_i  (stat_clr),
    .acc_i  (stat_acc),
    .hw_i   (hw),
    .min_o  (stat_min),
    .max_o  (stat_max),
    .sum_o  (stat_sum),
    .last_o (win_last)
  );

  // Select the frame byte that follows the one currently on the bus; the
  // stats registers are frozen while sending, so this is stable per index.
  always_comb begin
    nxt_idx = idx_q + 4'd1;
    sum_pad = '0;
    sum_pad[SUM_W-1:0] = stat_sum;
    min8 = 8'(stat_min);
    max8 = 8'(stat_max);
`ifdef TDC_READER_CHKSUM_EN
    nxt_byte_d = FRAME_HDR ^ seq_q ^ min8 ^ max8;
    for (int k = 0; k < SUM_BYTES; k++) nxt_byte_d = nxt_byte_d ^ sum_pad[8*k +: 8];
`else
    nxt_byte_d = 8'h00;
`endif
    case (nxt_idx)
      4'd1: nxt_byte_d = seq_q;
      4'd2: nxt_byte_d = min8;
      4'd3: nxt_byte_d = max8;
      default: begin
        if (nxt_idx >= 4'd4 && int'(nxt_idx) < 4 + SUM_BYTES)
          nxt_byte_d = sum_pad[8*(int'(nxt_idx) - 4) +: 8];
      end
    endcase
  end

  // Measurement FSM with registered frame outputs and busy flag.
  always_ff @(posedge clk_capture) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      seq_q        <= '0;
      settle_cnt_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q       <= 1'b1;
            settle_cnt_q <= '0;
            state_q      <= (SETTLE > 0) ? ST_SETTLE : ST_ACCUM;
          end
        end
        ST_SETTLE: begin
          if (en) begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
            if (settle_cnt_q == SETTLE_LAST) state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (win_last) begin
            state_q     <= ST_SEND;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= FRAME_HDR;
          end
        end
        ST_SEND: begin
          if (out_if.out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              seq_q       <= seq_q + 8'd1;
            end else begin
              idx_q      <= nxt_idx;
              out_data_q <= nxt_byte_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_tdc_frame_reader.sv
// Scoreboard bench for tdc_frame_reader: two instances (SETTLE=0 and SETTLE=2),
// expected frame bytes queued at stimulus time and popped on each handshake.
`timescale 1ns/1ps
module tb_tdc_frame_reader;

  localparam int N         = 64;
  localparam int LOG2_WIN  = 2;
  localparam int HW_W      = $clog2(N) + 1;
  localparam int SUM_W     = HW_W + LOG2_WIN;
  localparam int SUM_BYTES = (SUM_W + 7) / 8;
`ifdef TDC_READER_CHKSUM_EN
  localparam int FLEN = 5 + SUM_BYTES;
`else
  localparam int FLEN = 4 + SUM_BYTES;
`endif

  logic clk_capture = 1'b0;
  logic rst = 1'b1;
  always #5 clk_capture = ~clk_capture;

  logic            en    [2];
  logic            start [2];
  logic [HW_W-1:0] hw    [2];
  logic            rdy;
  bit              bp;
  logic            busy0, busy1;

  tdc_frame_reader_if bus0 ();
  tdc_frame_reader_if bus1 ();
  assign bus0.out_ready = rdy;
  assign bus1.out_ready = rdy;

  logic       ov [2];
  logic [7:0] od [2];
  logic       bz [2];
  assign ov[0] = bus0.out_valid;
  assign ov[1] = bus1.out_valid;
  assign od[0] = bus0.out_data;
  assign od[1] = bus1.out_data;
  assign bz[0] = busy0;
  assign bz[1] = busy1;

  tdc_frame_reader #(.N(N), .LOG2_WIN(LOG2_WIN), .SETTLE(0)) u_dut0 (
    .clk_capture (clk_capture),
    .rst         (rst),
    .en          (en[0]),
    .hw          (hw[0]),
    .start       (start[0]),
    .out_if      (bus0),
    .busy        (busy0)
  );

  tdc_frame_reader #(.N(N), .LOG2_WIN(LOG2_WIN), .SETTLE(2)) u_dut1 (
    .clk_capture (clk_capture),
    .rst         (rst),
    .en          (en[1]),
    .hw          (hw[1]),
    .start       (start[1]),
    .out_if      (bus1),
    .busy        (busy1)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q [2][$];
  logic [7:0] seq_m [2];
  int         hs_cnt [2];
  bit         hold [2];
  logic [7:0] hold_data [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake monitor: pop one expected byte per accepted byte, and check
  // that a byte offered while ready is low stays put on the next cycle.
  always @(negedge clk_capture) begin
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        hold[d] = 1'b0;
      end else begin
        if (hold[d]) begin
          check_eq($sformatf("hold_valid%0d", d), ov[d], 1);
          check_eq($sformatf("hold_data%0d", d), od[d], hold_data[d]);
        end
        if (ov[d] && rdy) begin
          hs_cnt[d]++;
          check_eq($sformatf("q_nonempty%0d", d), exp_q[d].size() != 0, 1);
          if (exp_q[d].size() != 0) begin
            e = exp_q[d].pop_front();
            check_eq($sformatf("byte%0d", d), od[d], e);
          end
        end
        hold[d]      = ov[d] && !rdy;
        hold_data[d] = od[d];
      end
    end
  end

  // Downstream ready: always high, or toggling every cycle in backpressure mode.
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk_capture);
      #1;
      rdy = bp ? ~rdy : 1'b1;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_frame(input int d, input int ns, input logic [HW_W-1:0] s [8]);
    int skip;
    logic [HW_W-1:0] mn, mx;
    logic [SUM_W-1:0] sm;
    logic [8*SUM_BYTES-1:0] sp;
    logic [7:0] fb [$];
    logic [7:0] x;
    skip = (d == 1) ? 2 : 0;
    mn = '1; mx = '0; sm = '0;
    for (int i = skip; i < ns; i++) begin
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
      sm = sm + SUM_W'(s[i]);
    end
    sp = '0;
    sp[SUM_W-1:0] = sm;
    fb.push_back(8'hA5);
    fb.push_back(seq_m[d]);
    fb.push_back(8'(mn));
    fb.push_back(8'(mx));
    for (int k = 0; k < SUM_BYTES; k++) fb.push_back(sp[8*k +: 8]);
`ifdef TDC_READER_CHKSUM_EN
    x = 8'h00;
    foreach (fb[i]) x = x ^ fb[i];
    fb.push_back(x);
`else
    x = 8'h00;
`endif
    foreach (fb[i]) exp_q[d].push_back(fb[i]);
  endtask

  task automatic run_frame(input int d, input int ns, input logic [HW_W-1:0] s [8],
                           input bit gaps, input bit pulse);
    bit done;
    expect_frame(d, ns, s);
    hs_cnt[d] = 0;
    start[d] = 1'b1;
    @(posedge clk_capture); #1;
    start[d] = 1'b0;
    check_eq("busy_after_start", bz[d], 1);
    for (int i = 0; i < ns; i++) begin
      if (gaps) begin
        en[d] = 1'b0; hw[d] = 7'd63;
        @(posedge clk_capture); #1;
      end
      en[d] = 1'b1; hw[d] = s[i];
      if (pulse && i == 1) start[d] = 1'b1;
      @(posedge clk_capture); #1;
      start[d] = 1'b0;
    end
    en[d] = 1'b0;
    check_eq("first_valid", ov[d], 1);
    if (pulse) begin
      start[d] = 1'b1;
      @(posedge clk_capture); #1;
      start[d] = 1'b0;
    end
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk_capture); #1;
      done = !bz[d] && (exp_q[d].size() == 0);
    end
    check_eq("frame_done", done, 1);
    check_eq("handshakes", hs_cnt[d], FLEN);
    seq_m[d] = seq_m[d] + 8'd1;
  endtask

  initial begin
    logic [HW_W-1:0] smp [8];
    bit done;
    bp = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; start[d] = 1'b0; hw[d] = '0; seq_m[d] = 8'h00; hs_cnt[d] = 0;
    end
    foreach (smp[i]) smp[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk_capture);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_valid", ov[d], 0);
      check_eq("rst_data", od[d], 0);
      check_eq("rst_busy", bz[d], 0);
    end
    rst = 1'b0;
    @(posedge clk_capture); #1;

    // basic frame
    smp[0] = 7'd10; smp[1] = 7'd20; smp[2] = 7'd30; smp[3] = 7'd40;
    run_frame(0, 4, smp, 1'b0, 1'b0);

    // backpressure
    bp = 1'b1;
    smp[0] = 7'd1; smp[1] = 7'd2; smp[2] = 7'd3; smp[3] = 7'd4;
    run_frame(0, 4, smp, 1'b0, 1'b0);
    bp = 1'b0;
    @(posedge clk_capture); #1;

    // settle and en gaps on the SETTLE=2 instance
    smp[0] = 7'd63; smp[1] = 7'd63; smp[2] = 7'd5; smp[3] = 7'd5; smp[4] = 7'd5; smp[5] = 7'd5;
    run_frame(1, 6, smp, 1'b1, 1'b0);

    // reset after the second handshake
    smp[0] = 7'd11; smp[1] = 7'd22; smp[2] = 7'd33; smp[3] = 7'd44;
    expect_frame(0, 4, smp);
    hs_cnt[0] = 0;
    start[0] = 1'b1;
    @(posedge clk_capture); #1;
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[0] = 1'b1; hw[0] = smp[i];
      @(posedge clk_capture); #1;
    end
    en[0] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk_capture); #1;
      done = (hs_cnt[0] >= 2);
    end
    check_eq("reach_hs2", done, 1);
    rst = 1'b1;
    @(posedge clk_capture); #1;
    check_eq("midrst_valid", ov[0], 0);
    check_eq("midrst_busy", bz[0], 0);
    check_eq("midrst_data", od[0], 0);
    check_eq("midrst_hs", hs_cnt[0], 2);
    rst = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    seq_m[0] = 8'h00;
    seq_m[1] = 8'h00;
    smp[0] = 7'd7; smp[1] = 7'd3; smp[2] = 7'd9; smp[3] = 7'd1;
    run_frame(0, 4, smp, 1'b0, 1'b0);

    // ignored start during ACCUM/SEND, extreme values
    smp[0] = 7'd0; smp[1] = 7'd64; smp[2] = 7'd64; smp[3] = 7'd64;
    run_frame(0, 4, smp, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_capture); #1;
      check_eq("no_restart", bz[0], 0);
      check_eq("no_restart_valid", ov[0], 0);
    end

    // sequence wrap: last of these frames carries seq 00
    for (int f = 0; f < 255; f++) begin
      for (int i = 0; i < 4; i++) smp[i] = HW_W'($urandom_range(0, 64));
      run_frame(0, 4, smp, 1'b0, 1'b0);
    end
    smp[0] = 7'd2; smp[1] = 7'd4; smp[2] = 7'd6; smp[3] = 7'd8;
    run_frame(0, 4, smp, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
